// File: rtl/counter_seq_ctrl_if.sv
// counter_seq_ctrl_if: valid/ready command port of the counter sequencer
interface counter_seq_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [WIDTH-1:0] cmd_data;
  modport master (output cmd_valid, cmd_op, cmd_data, input cmd_ready);
  modport slave  (input cmd_valid, cmd_op, cmd_data, output cmd_ready);
endinterface

// File: rtl/counter_seq_ctrl.sv
// counter_seq_ctrl: command-driven load/enable/direction sequencer for a counter core; define COUNTER_SEQ_PRESCALE_EN to step only every PRESCALE+1 RUN cycles
module counter_seq_ctrl #(
  parameter int WIDTH    = 8,
  parameter int PRESCALE = 3
) (
  input  logic              clk,
  input  logic              rst,
  counter_seq_ctrl_if.slave cmd,
  input  logic [WIDTH-1:0]  cnt_value,
  output logic              cnt_en,
  output logic              cnt_load,
  output logic [WIDTH-1:0]  cnt_load_val,
  output logic              cnt_up,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        state
);
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_LOAD = 2'd1, S_RUN = 2'd2, S_DONE = 2'd3} state_t;
  localparam logic [1:0] OP_LIMIT = 2'd0;
  localparam logic [1:0] OP_LOAD  = 2'd1;
  localparam logic [1:0] OP_START = 2'd2;
  localparam logic [1:0] OP_STOP  = 2'd3;
  state_t           r_state;
  logic [WIDTH-1:0] r_limit;
  logic [WIDTH-1:0] r_start;
  logic [WIDTH-1:0] r_load_val;
  logic             r_up;
  logic             r_reload;
  logic             r_load;
  logic             r_done;
  logic             r_err;
  logic             w_acc;
  logic             w_stop;
  logic             w_run;
  logic             w_term;
  logic             w_tick;
  assign cmd.cmd_ready = r_state != S_LOAD;
  assign w_acc         = cmd.cmd_valid && cmd.cmd_ready;
  assign w_stop        = w_acc && cmd.cmd_op == OP_STOP;
  assign w_run         = r_state == S_RUN;
  assign w_term        = w_run && cnt_value == r_limit;
`ifdef COUNTER_SEQ_PRESCALE_EN
  localparam int DW = $clog2(PRESCALE + 2);
  logic [DW-1:0] r_div;
  assign w_tick = r_div == DW'(PRESCALE);
  // tick divider: counts RUN cycles, held at zero outside RUN so each run starts a fresh period
  always_ff @(posedge clk)
    if (rst || !w_run || w_tick) r_div <= '0;
    else r_div <= r_div + DW'(1);
`else
  logic w_unused;
  assign w_unused = ^PRESCALE;
  assign w_tick   = 1'b1;
`endif
  assign cnt_en       = !rst && w_run && w_tick && !w_term && !w_stop;
  assign cnt_load     = r_load;
  assign cnt_load_val = r_load_val;
  assign cnt_up       = r_up;
  assign done         = r_done;
  assign err          = r_err;
  assign state        = r_state;
  assign busy         = r_state == S_LOAD || w_run;
  // sequencer FSM: command decode, load strobe, terminal detection and status pulses
  always_ff @(posedge clk)
    if (rst) begin
      r_state    <= S_IDLE;
      r_limit    <= '1;
      r_start    <= '0;
      r_load_val <= '0;
      r_up       <= 1'b1;
      r_reload   <= 1'b0;
      r_load     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_load <= 1'b0;
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE:
          if (w_acc)
            case (cmd.cmd_op)
              OP_LIMIT: r_limit <= cmd.cmd_data;
              OP_LOAD:  r_start <= cmd.cmd_data;
              OP_START: begin
                r_up       <= cmd.cmd_data[0];
                r_reload   <= cmd.cmd_data[1];
                r_load     <= 1'b1;
                r_load_val <= r_start;
                r_state    <= S_LOAD;
              end
              default:  r_state <= S_IDLE;
            endcase
        S_LOAD: r_state <= S_RUN;
        default:
          if (w_stop) r_state <= S_IDLE;
          else begin
            r_err <= w_acc;
            if (w_term) begin
              r_done     <= 1'b1;
              r_load     <= r_reload;
              r_load_val <= r_start;
              r_state    <= r_reload ? S_LOAD : S_DONE;
            end
          end
      endcase
    end
endmodule

// File: tb/tb_counter_seq_ctrl.sv
// tb_counter_seq_ctrl: randomized scoreboard bench with an event-timing reference model
module tb_counter_seq_ctrl;
  localparam logic [1:0] OP_LIMIT = 2'd0;
  localparam logic [1:0] OP_LOAD  = 2'd1;
  localparam logic [1:0] OP_START = 2'd2;
  localparam logic [1:0] OP_STOP  = 2'd3;
`ifdef COUNTER_SEQ_PRESCALE_EN
  localparam int P = 3;
`else
  localparam int P = 0;
`endif
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] cnt_value = '0;
  logic       cnt_en, cnt_load, cnt_up, busy, done, err;
  logic [7:0] cnt_load_val;
  logic [1:0] state;
  int         cyc = 0;
  int         en_cnt = 0;
  int         total = 0;
  int         bad = 0;
  int         q_load_c[$];
  int         q_load_v[$];
  int         q_done[$];
  int         q_err[$];
  logic [7:0] m_limit = 8'hFF;
  logic [7:0] m_start = 8'h00;
  counter_seq_ctrl_if #(.WIDTH(8)) cmd_if ();
  counter_seq_ctrl #(.WIDTH(8), .PRESCALE(3)) dut (
    .clk(clk), .rst(rst), .cmd(cmd_if.slave), .cnt_value(cnt_value),
    .cnt_en(cnt_en), .cnt_load(cnt_load), .cnt_load_val(cnt_load_val), .cnt_up(cnt_up),
    .busy(busy), .done(done), .err(err), .state(state)
  );
  always #5 clk = ~clk;
  // counter core stand-in plus cycle and enable bookkeeping
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (cnt_en) en_cnt <= en_cnt + 1;
    if (cnt_load) cnt_value <= cnt_load_val;
    else if (cnt_en) cnt_value <= cnt_up ? cnt_value + 8'd1 : cnt_value - 8'd1;
  end
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d cyc=%0d", n, a, e, cyc);
    end
  endtask
  task automatic miss(input string n);
    total++;
    bad++;
    $display("FAIL %s got=pulse want=none cyc=%0d", n, cyc);
  endtask
  // monitor: pops the scoreboard whenever the DUT presents a strobe
  always @(negedge clk) begin
    #1;
    if (rst) chk("en_in_rst", cnt_en, 0);
    else begin
      if (cnt_load) begin
        if (q_load_c.size() == 0) miss("load_unexpected");
        else begin
          chk("load_cyc", cyc, q_load_c.pop_front());
          chk("load_val", cnt_load_val, q_load_v.pop_front());
        end
      end
      if (done) begin
        if (q_done.size() == 0) miss("done_unexpected");
        else chk("done_cyc", cyc, q_done.pop_front());
      end
      if (err) begin
        if (q_err.size() == 0) miss("err_unexpected");
        else chk("err_cyc", cyc, q_err.pop_front());
      end
    end
  end
  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask
  task automatic send(input logic [1:0] op, input logic [7:0] d, input int t, output int k);
    int n = 0;
    do @(negedge clk); while (cyc < t);
    while (!cmd_if.cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    k = cyc;
    if (!cmd_if.cmd_ready) miss("ready_timeout");
    else begin
      cmd_if.cmd_valid = 1'b1;
      cmd_if.cmd_op    = op;
      cmd_if.cmd_data  = d;
      #1;
      if (op == OP_STOP) chk("stop_en", cnt_en, 0);
      @(negedge clk);
      cmd_if.cmd_valid = 1'b0;
    end
  endtask
  task automatic chk_reset(input string n);
    chk({n, "_state"}, state, 0);
    chk({n, "_en"}, cnt_en, 0);
    chk({n, "_load"}, cnt_load, 0);
    chk({n, "_loadval"}, cnt_load_val, 0);
    chk({n, "_up"}, cnt_up, 1);
    chk({n, "_done"}, done, 0);
    chk({n, "_err"}, err, 0);
    chk({n, "_busy"}, busy, 0);
  endtask
  // one run: expected strobe cycles follow from distance*(P+1) arithmetic;
  // np reload periods complete before a STOP at offset spo into the next one (spo<0: no STOP),
  // eo>=0 injects an illegal command eo cycles after the load cycle
  task automatic do_run(input logic [7:0] s, input logic [7:0] l, input bit up, input bit rl,
                        input bit setlim, input int np, input int spo, input int eo);
    int k, d, per, x0, sp, en0;
    logic [7:0] dv;
    send(OP_LOAD, s, 0, k);
    m_start = s;
    if (setlim) begin
      send(OP_LIMIT, l, 0, k);
      m_limit = l;
    end
    dv  = up ? m_limit - s : s - m_limit;
    d   = int'(dv);
    per = d * (P + 1) + 2;
    en0 = en_cnt;
    send(OP_START, {6'b0, rl, up}, 0, k);
    x0 = k + 1;
    sp = x0 + np * per + spo;
    for (int j = 0; j <= np; j++) begin
      q_load_c.push_back(x0 + j * per);
      q_load_v.push_back(int'(m_start));
    end
    for (int j = 0; j < np; j++) q_done.push_back(x0 + (j + 1) * per);
    if (spo < 0) q_done.push_back(x0 + per);
    if (eo >= 0) q_err.push_back(x0 + eo + 1);
    chk("busy_load", busy, 1);
    chk("ready_load", cmd_if.cmd_ready, 0);
    chk("up_dir", cnt_up, up);
    if (eo >= 0) send(2'($urandom_range(0, 2)), 8'($urandom), x0 + eo, k);
    if (spo < 0) begin
      wait_cyc(x0 + per);
      #1;
      chk("state_done", state, 3);
      chk("busy_done", busy, 0);
      chk("cnt_final", cnt_value, m_limit);
      chk("en_cycles", en_cnt - en0, d);
    end else begin
      send(OP_STOP, 8'd0, sp, k);
      chk("stop_cyc", k, sp);
      wait_cyc(sp + 1);
      #1;
      chk("state_stop", state, 0);
    end
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog got=running want=finished");
    $fatal(1);
  end
  initial begin
    int k, dd, per, np, spo, eo, emax;
    logic [7:0] s, l;
    bit up, rl, stp;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_op    = 2'd0;
    cmd_if.cmd_data  = 8'd0;
    repeat (3) @(negedge clk);
    #1;
    chk_reset("rst_hold");
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk_reset("rst_rel");
    chk("ready_idle", cmd_if.cmd_ready, 1);
    do_run(8'd250, 8'hFF, 1, 0, 0, 0, -1, -1);
    do_run(8'd0, 8'd5, 1, 0, 1, 0, -1, -1);
    do_run(8'd10, 8'd7, 0, 0, 1, 0, -1, -1);
    do_run(8'd0, 8'd2, 1, 1, 1, 2, 2, -1);
    do_run(8'd0, 8'd5, 1, 0, 1, 0, 6, 4);
    do_run(8'd250, 8'd3, 1, 0, 1, 0, -1, -1);
    do_run(8'd9, 8'd9, 0, 0, 1, 0, -1, -1);
    send(OP_LOAD, 8'd100, 0, k);
    send(OP_LIMIT, 8'd0, 0, k);
    send(OP_START, 8'd0, 0, k);
    q_load_c.push_back(k + 1);
    q_load_v.push_back(100);
    wait_cyc(k + 4);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk_reset("rst_mid");
    m_limit = 8'hFF;
    m_start = 8'h00;
    for (int i = 0; i < 40; i++) begin
      s    = 8'($urandom);
      dd   = $urandom_range(0, 6);
      up   = 1'($urandom);
      l    = up ? s + 8'(dd) : s - 8'(dd);
      rl   = $urandom_range(0, 3) == 0;
      per  = dd * (P + 1) + 2;
      np   = rl ? $urandom_range(0, 2) : 0;
      stp  = rl || $urandom_range(0, 2) == 0;
      spo  = stp ? $urandom_range(1, per - 1) : -1;
      emax = stp ? np * per + spo - 2 : per - 1;
      if (emax > per - 1) emax = per - 1;
      eo   = (emax >= 1 && $urandom_range(0, 1) == 1) ? $urandom_range(1, emax) : -1;
      do_run(s, l, up, rl, 1, np, spo, eo);
    end
    repeat (4) @(negedge clk);
    chk("load_left", q_load_c.size(), 0);
    chk("done_left", q_done.size(), 0);
    chk("err_left", q_err.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
